// File: rtl/bpsk_rx_correlator.sv
// BPSK receiver: correlates each symbol against a local sine, slices one bit per symbol and packs
// bits MSB-first into words. Define BPSK_RX_CONF_EN to add low_conf / err_cnt confidence outputs.
module bpsk_rx_correlator #(
    parameter int unsigned SAMPLE_NUMBER = 256,
    parameter int unsigned SAMPLE_WIDTH  = 12,
    parameter int unsigned DATA_WIDTH    = 12
`ifdef BPSK_RX_CONF_EN
    ,
    parameter longint unsigned CONF_THRESH = 64'd1 << (2 * SAMPLE_WIDTH - 2)
`endif
) (
    input  logic                    clk,
    input  logic                    arst,
    input  logic                    en,
    input  logic                    sym_sync,
    input  logic [SAMPLE_WIDTH-1:0] sample_in,
    output logic                    bit_out,
    output logic                    bit_valid,
    output logic [DATA_WIDTH-1:0]   q,
    output logic                    q_valid
`ifdef BPSK_RX_CONF_EN
    ,
    output logic                    low_conf,
    output logic [15:0]             err_cnt
`endif
);

    localparam int unsigned KW = $clog2(SAMPLE_NUMBER);
    localparam int unsigned PW = 2 * SAMPLE_WIDTH;
    localparam int unsigned AW = PW + KW;
    localparam int unsigned CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam real Pi  = 3.14159265358979323846;
    localparam real Amp = real'((1 << (SAMPLE_WIDTH - 1)) - 1);

    // Reference sine table, rounded half away from zero at elaboration.
    logic signed [SAMPLE_WIDTH-1:0] sine_lut [SAMPLE_NUMBER];
    for (genvar i = 0; i < SAMPLE_NUMBER; i++) begin : g_lut
        localparam real Val = Amp * $sin(2.0 * Pi * real'(i) / real'(SAMPLE_NUMBER));
        localparam int  Rnd = (Val >= 0.0) ? $rtoi(Val + 0.5) : -$rtoi(0.5 - Val);
        assign sine_lut[i] = Rnd[SAMPLE_WIDTH-1:0];
    end

    logic [KW-1:0]                  k_q, k_idx;
    logic                           s1_valid_q, s1_first_q, s1_last_q;
    logic signed [SAMPLE_WIDTH-1:0] s1_s_q, s1_ref_q, s_in;
    logic                           s2_valid_q, s2_first_q, s2_last_q;
    logic signed [PW-1:0]           s2_prod_q;
    logic                           s3_valid_q, s3_last_q;
    logic signed [AW-1:0]           acc_q, prod_ext;
    logic                           dec_valid_q, dec_bit_q;
    logic [CW-1:0]                  bit_cnt_q;
    logic [DATA_WIDTH-1:0]          shift_q, shift_next;

    assign s_in       = {~sample_in[SAMPLE_WIDTH-1], sample_in[SAMPLE_WIDTH-2:0]};
    assign k_idx      = sym_sync ? '0 : k_q;
    assign prod_ext   = {{KW{s2_prod_q[PW-1]}}, s2_prod_q};
    assign shift_next = DATA_WIDTH'({shift_q, dec_bit_q});

`ifdef BPSK_RX_CONF_EN
    logic [AW-1:0] acc_abs;
    logic          dec_low_q;
    assign acc_abs = acc_q[AW-1] ? -acc_q : acc_q;
`endif

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            k_q         <= '0;
            s1_valid_q  <= 1'b0;
            s1_first_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_s_q      <= '0;
            s1_ref_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_first_q  <= 1'b0;
            s2_last_q   <= 1'b0;
            s2_prod_q   <= '0;
            s3_valid_q  <= 1'b0;
            s3_last_q   <= 1'b0;
            acc_q       <= '0;
            dec_valid_q <= 1'b0;
            dec_bit_q   <= 1'b0;
`ifdef BPSK_RX_CONF_EN
            dec_low_q   <= 1'b0;
`endif
        end else begin
            // A sample accepted together with sym_sync is index 0 of the new symbol.
            k_q        <= en ? k_idx + KW'(1) : k_idx;
            s1_valid_q <= en;
            if (en) begin
                s1_s_q     <= s_in;
                s1_ref_q   <= sine_lut[k_idx];
                s1_first_q <= (k_idx == '0);
                s1_last_q  <= &k_idx;
            end
            s2_valid_q <= s1_valid_q && !sym_sync;
            if (s1_valid_q) begin
                s2_prod_q  <= s1_s_q * s1_ref_q;
                s2_first_q <= s1_first_q;
                s2_last_q  <= s1_last_q;
            end
            s3_valid_q <= s2_valid_q && !sym_sync;
            s3_last_q  <= s2_last_q;
            if (sym_sync) begin
                acc_q <= '0;
            end else if (s2_valid_q) begin
                acc_q <= s2_first_q ? prod_ext : acc_q + prod_ext;
            end
            // Decision register keeps bit_valid 4 clk after the last sample is accepted.
            dec_valid_q <= s3_valid_q && s3_last_q && !sym_sync;
            if (s3_valid_q && s3_last_q) begin
                dec_bit_q <= !acc_q[AW-1] && (|acc_q);
`ifdef BPSK_RX_CONF_EN
                dec_low_q <= 64'(acc_abs) < CONF_THRESH;
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
            q         <= '0;
            q_valid   <= 1'b0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
        end else begin
            bit_valid <= 1'b0;
            q_valid   <= 1'b0;
            if (sym_sync) begin
                bit_cnt_q <= '0;
                shift_q   <= '0;
            end else if (dec_valid_q) begin
                bit_out   <= dec_bit_q;
                bit_valid <= 1'b1;
                shift_q   <= shift_next;
                if (bit_cnt_q == CW'(DATA_WIDTH - 1)) begin
                    q         <= shift_next;
                    q_valid   <= 1'b1;
                    bit_cnt_q <= '0;
                end else begin
                    bit_cnt_q <= bit_cnt_q + CW'(1);
                end
            end
        end
    end

`ifdef BPSK_RX_CONF_EN
    // err_cnt survives sym_sync; only arst clears it.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            low_conf <= 1'b0;
            err_cnt  <= '0;
        end else if (dec_valid_q && !sym_sync) begin
            low_conf <= dec_low_q;
            if (dec_low_q && (err_cnt != 16'hFFFF)) begin
                err_cnt <= err_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_bpsk_rx_correlator.sv
// Directed self-checking bench for bpsk_rx_correlator (default parameters).
// Build with BPSK_RX_CONF_EN defined to also check low_conf / err_cnt.
module tb_bpsk_rx_correlator;

    logic        clk = 1'b0;
    logic        arst;
    logic        en;
    logic        sym_sync;
    logic [11:0] sample_in;
    logic        bit_out;
    logic        bit_valid;
    logic [11:0] q;
    logic        q_valid;
`ifdef BPSK_RX_CONF_EN
    logic        low_conf;
    logic [15:0] err_cnt;
`endif

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int last_acc;
    int exp_bv[$];
    int bv_cyc[$];
    logic bits[$];
    int bv_cnt, qv_cnt, qv_cyc, lc_cnt;
    logic [11:0] q_seen;
    bit toggle_mode = 1'b0;

    bpsk_rx_correlator #(
        .SAMPLE_NUMBER(256),
        .SAMPLE_WIDTH (12),
        .DATA_WIDTH   (12)
`ifdef BPSK_RX_CONF_EN
        ,
        .CONF_THRESH  (64'd1 << 27)
`endif
    ) dut (
        .clk      (clk),
        .arst     (arst),
        .en       (en),
        .sym_sync (sym_sync),
        .sample_in(sample_in),
        .bit_out  (bit_out),
        .bit_valid(bit_valid),
        .q        (q),
        .q_valid  (q_valid)
`ifdef BPSK_RX_CONF_EN
        ,
        .low_conf (low_conf),
        .err_cnt  (err_cnt)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (bit_valid === 1'b1) begin
            bv_cnt++;
            bv_cyc.push_back(cyc);
            bits.push_back(bit_out);
`ifdef BPSK_RX_CONF_EN
            if (low_conf === 1'b1) lc_cnt++;
`endif
        end
        if (q_valid === 1'b1) begin
            qv_cnt++;
            qv_cyc = cyc;
            q_seen = q;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int ref_val(input int k);
        real x;
        x = 2047.0 * $sin(2.0 * 3.14159265358979 * k / 256.0);
        return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
    endfunction

    task automatic clear_mon();
        bv_cnt = 0;
        qv_cnt = 0;
        qv_cyc = -1;
        lc_cnt = 0;
        q_seen = 12'h000;
        bv_cyc.delete();
        bits.delete();
        exp_bv.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            en       = 1'b0;
            sym_sync = 1'b0;
        end
    endtask

    task automatic drive_sample(input logic [11:0] smp, input logic sync);
        @(negedge clk);
        en        = 1'b1;
        sym_sync  = sync;
        sample_in = smp;
        last_acc  = cyc + 1;
        if (toggle_mode) begin
            @(negedge clk);
            en        = 1'b0;
            sym_sync  = 1'b0;
            sample_in = 12'($urandom_range(0, 4095));
        end
    endtask

    // Transmitter model: bit 1 sends +sin, bit 0 sends -sin, scaled by 2^-shift plus noise.
    task automatic send_symbol(input logic b, input int shift, input int noise, input logic sync,
                               input int nsamp);
        int v;
        for (int k = 0; k < nsamp; k++) begin
            v = ref_val(k) >>> shift;
            if (!b) v = -v;
            if (noise > 0) v += int'($urandom_range(0, 2 * noise)) - noise;
            drive_sample(12'(v + 2048), sync && (k == 0));
            if (k == 255) exp_bv.push_back(last_acc + 4);
        end
    endtask

    task automatic send_word(input logic [11:0] w, input int shift, input int noise);
        for (int i = 11; i >= 0; i--) send_symbol(w[i], shift, noise, (i == 11), 256);
    endtask

    task automatic test_reset();
        arst = 1'b1; en = 1'b0; sym_sync = 1'b0; sample_in = 12'd0;
        repeat (3) @(negedge clk);
        checks++; if (bit_valid !== 1'b0) begin fails++; $display("FAIL reset_bit_valid got %b want 0", bit_valid); end
        checks++; if (q_valid !== 1'b0) begin fails++; $display("FAIL reset_q_valid got %b want 0", q_valid); end
        checks++; if (q !== 12'h000) begin fails++; $display("FAIL reset_q got %h want 000", q); end
        checks++; if (bit_out !== 1'b0) begin fails++; $display("FAIL reset_bit_out got %b want 0", bit_out); end
        arst = 1'b0;
        clear_mon();
        send_symbol(1'b0, 0, 0, 1'b1, 100);
        @(negedge clk); en = 1'b0; arst = 1'b1;
        @(negedge clk);
        checks++; if (bit_valid !== 1'b0 || q_valid !== 1'b0) begin fails++; $display("FAIL reset_mid_valids got %b%b want 00", bit_valid, q_valid); end
        @(negedge clk); arst = 1'b0;
        clear_mon();
        // No sym_sync: the first sample after reset must be index 0.
        send_symbol(1'b1, 0, 0, 1'b0, 256);
        idle(8);
        checks++; if (bv_cnt != 1) begin fails++; $display("FAIL reset_bit_count got %0d want 1", bv_cnt); end
        checks++; if (bits.size() == 0 || bits[0] !== 1'b1) begin fails++; $display("FAIL reset_first_bit got %b want 1", (bits.size() != 0) ? bits[0] : 1'bx); end
        checks++; if (bv_cyc.size() == 0 || exp_bv.size() == 0 || bv_cyc[0] != exp_bv[0]) begin fails++; $display("FAIL reset_latency got %0d want %0d", (bv_cyc.size() != 0) ? bv_cyc[0] : -1, (exp_bv.size() != 0) ? exp_bv[0] : -1); end
        checks++; if (qv_cnt != 0) begin fails++; $display("FAIL reset_no_word got %0d want 0", qv_cnt); end
    endtask

    task automatic test_full_scale();
        logic [11:0] w;
        w = 12'hA5C;
        clear_mon();
        send_word(w, 0, 0);
        idle(8);
        checks++; if (qv_cnt != 1) begin fails++; $display("FAIL full_q_valid_count got %0d want 1", qv_cnt); end
        checks++; if (q_seen !== w) begin fails++; $display("FAIL full_q got %h want %h", q_seen, w); end
        checks++; if (bv_cnt != 12) begin fails++; $display("FAIL full_bit_count got %0d want 12", bv_cnt); end
        for (int i = 0; i < 12; i++) begin
            if (i < bits.size() && i < bv_cyc.size() && i < exp_bv.size()) begin
                checks++; if (bits[i] !== w[11-i]) begin fails++; $display("FAIL full_bit[%0d] got %b want %b", i, bits[i], w[11-i]); end
                checks++; if (bv_cyc[i] != exp_bv[i]) begin fails++; $display("FAIL full_latency[%0d] got %0d want %0d", i, bv_cyc[i], exp_bv[i]); end
            end
        end
        checks++; if (bv_cyc.size() < 12 || qv_cyc != bv_cyc[11]) begin fails++; $display("FAIL full_q_valid_align got %0d want last bit cycle", qv_cyc); end
        checks++; if (q !== w) begin fails++; $display("FAIL full_q_hold got %h want %h", q, w); end
    endtask

    task automatic test_en_toggle();
        clear_mon();
        toggle_mode = 1'b1;
        send_word(12'h3C1, 0, 0);
        toggle_mode = 1'b0;
        idle(8);
        checks++; if (qv_cnt != 1) begin fails++; $display("FAIL toggle_q_valid_count got %0d want 1", qv_cnt); end
        checks++; if (q_seen !== 12'h3C1) begin fails++; $display("FAIL toggle_q got %h want 3c1", q_seen); end
        checks++; if (bv_cnt != 12) begin fails++; $display("FAIL toggle_bit_count got %0d want 12", bv_cnt); end
        checks++; if (exp_bv.size() < 12 || qv_cyc != exp_bv[11]) begin fails++; $display("FAIL toggle_q_valid_time got %0d want %0d", qv_cyc, (exp_bv.size() >= 12) ? exp_bv[11] : -1); end
    endtask

    task automatic test_sync_abort();
        logic [3:0] head;
        head = 4'b1011;
        clear_mon();
        for (int i = 3; i >= 0; i--) send_symbol(head[i], 0, 0, (i == 3), 256);
        send_symbol(1'b0, 0, 0, 1'b0, 100);
        send_word(12'hFFF, 0, 0);
        idle(8);
        checks++; if (qv_cnt != 1) begin fails++; $display("FAIL abort_q_valid_count got %0d want 1", qv_cnt); end
        checks++; if (q_seen !== 12'hFFF) begin fails++; $display("FAIL abort_q got %h want fff", q_seen); end
        checks++; if (bv_cnt != 16) begin fails++; $display("FAIL abort_bit_count got %0d want 16", bv_cnt); end
        for (int i = 0; i < 4; i++) begin
            if (i < bits.size()) begin
                checks++; if (bits[i] !== head[3-i]) begin fails++; $display("FAIL abort_head_bit[%0d] got %b want %b", i, bits[i], head[3-i]); end
            end
        end
    endtask

    task automatic test_sync_collision();
        clear_mon();
        send_symbol(1'b1, 0, 0, 1'b1, 256);
        @(negedge clk); en = 1'b0;
        // Lands on the edge where the last sample's sum completes in the accumulator.
        @(negedge clk); sym_sync = 1'b1;
        idle(8);
        checks++; if (bv_cnt != 0) begin fails++; $display("FAIL collision_bit_count got %0d want 0", bv_cnt); end
    endtask

    task automatic test_midscale();
        clear_mon();
        for (int k = 0; k < 256; k++) drive_sample(12'd2048, (k == 0));
        idle(8);
        checks++; if (bv_cnt != 1) begin fails++; $display("FAIL mid_bit_count got %0d want 1", bv_cnt); end
        checks++; if (bits.size() == 0 || bits[0] !== 1'b0) begin fails++; $display("FAIL mid_tie_bit got %b want 0", (bits.size() != 0) ? bits[0] : 1'bx); end
        checks++; if (qv_cnt != 0) begin fails++; $display("FAIL mid_no_word got %0d want 0", qv_cnt); end
`ifdef BPSK_RX_CONF_EN
        checks++; if (lc_cnt != 1) begin fails++; $display("FAIL mid_low_conf got %0d want 1", lc_cnt); end
        checks++; if (err_cnt !== 16'd1) begin fails++; $display("FAIL mid_err_cnt got %0d want 1", err_cnt); end
`endif
    endtask

    task automatic test_low_amp();
        @(negedge clk); arst = 1'b1;
        @(negedge clk); arst = 1'b0;
        clear_mon();
        send_word(12'h5A5, 3, 3);
        idle(8);
        checks++; if (qv_cnt != 1) begin fails++; $display("FAIL lowamp_q_valid_count got %0d want 1", qv_cnt); end
        checks++; if (q_seen !== 12'h5A5) begin fails++; $display("FAIL lowamp_q got %h want 5a5", q_seen); end
        checks++; if (bv_cnt != 12) begin fails++; $display("FAIL lowamp_bit_count got %0d want 12", bv_cnt); end
`ifdef BPSK_RX_CONF_EN
        checks++; if (lc_cnt != 12) begin fails++; $display("FAIL lowamp_low_conf got %0d want 12", lc_cnt); end
        checks++; if (err_cnt !== 16'd12) begin fails++; $display("FAIL lowamp_err_cnt got %0d want 12", err_cnt); end
`endif
    endtask

    initial begin
        test_reset();
        test_full_scale();
        test_en_toggle();
        test_sync_abort();
        test_sync_collision();
        test_midscale();
        test_low_amp();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
